// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends a captured WIDTH-bit pattern MSB first, repeated
// `reps` times with GAP idle cycles between repetitions, then pulses done.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    output logic             A,
    output logic             first,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT    = 2'd1;
    localparam logic [1:0] GAP_WAIT = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [1:0]       state;
    logic [WIDTH-1:0] pat_reg;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    bit_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [3:0]       gap_cnt;

    // A is registered, so the MSB is driven straight from the source while the
    // shift register is loaded with the remaining bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat_reg <= '0;
            sh      <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            A       <= 1'b0;
            first   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reps != '0) begin
                            pat_reg <= pattern;
                            sh      <= {pattern[WIDTH-2:0], 1'b0};
                            rep_cnt <= reps;
                            bit_cnt <= '0;
                            A       <= pattern[WIDTH-1];
                            first   <= 1'b1;
                            busy    <= 1'b1;
                            state   <= SHIFT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rep_cnt == REP_W'(1)) begin
                            rep_cnt <= '0;
                            A       <= 1'b0;
                            first   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            rep_cnt <= rep_cnt - REP_W'(1);
                            if (GAP > 0) begin
                                gap_cnt <= '0;
                                A       <= 1'b0;
                                first   <= 1'b0;
                                state   <= GAP_WAIT;
                            end else begin
                                A     <= pat_reg[WIDTH-1];
                                sh    <= {pat_reg[WIDTH-2:0], 1'b0};
                                first <= 1'b1;
                            end
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        A       <= sh[WIDTH-1];
                        sh      <= {sh[WIDTH-2:0], 1'b0};
                        first   <= 1'b0;
                    end
                end

                GAP_WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        A       <= pat_reg[WIDTH-1];
                        sh      <= {pat_reg[WIDTH-2:0], 1'b0};
                        first   <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench: two generators (GAP=0 and GAP=2) share stimulus; a cycle-stamped
// expected stream per instance is compared every cycle, zero expected when none is due.
module tb_serial_pattern_gen;

    localparam int BIG = 1 << 30;

    typedef struct {
        int         t;
        logic [3:0] v;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] reps;
    logic       a0, first0, busy0, done0;
    logic       a2, first2, busy2, done2;

    int   cyc;
    int   tlast;
    int   n_checks;
    int   n_fail;
    logic chk_en;
    exp_t q0[$];
    exp_t q2[$];

    serial_pattern_gen #(.WIDTH(8), .REP_W(4), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps),
        .A(a0), .first(first0), .busy(busy0), .done(done0)
    );

    serial_pattern_gen #(.WIDTH(8), .REP_W(4), .GAP(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps),
        .A(a2), .first(first2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got {A,first,busy,done}=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int g, input int t, input logic [3:0] v, input int cut);
        exp_t e;
        if (t <= cut) begin
            e.t = t;
            e.v = v;
            if (g == 0) q0.push_back(e);
            else        q2.push_back(e);
        end
    endtask

    // Expected outputs of one transmission whose start is sampled at the end of cycle t0.
    task automatic model(input int g, input logic [7:0] p, input int r, input int t0,
                         input int cut, output int tdone);
        int t = t0 + 1;
        for (int rep = 0; rep < r; rep++) begin
            for (int b = 0; b < 8; b++) begin
                push(g, t, {p[7-b], (b == 0), 1'b1, 1'b0}, cut);
                t++;
            end
            if (rep < r - 1) begin
                for (int k = 0; k < g; k++) begin
                    push(g, t, 4'b0010, cut);
                    t++;
                end
            end
        end
        push(g, t, 4'b0001, cut);
        tdone = t;
        if (t > tlast) tlast = t;
    endtask

    always @(negedge clk) begin
        logic [3:0] e0;
        logic [3:0] e2;
        if (chk_en) begin
            e0 = '0;
            e2 = '0;
            if (q0.size() > 0 && q0[0].t == cyc) begin
                e0 = q0[0].v;
                q0.delete(0);
            end
            if (q2.size() > 0 && q2[0].t == cyc) begin
                e2 = q2[0].v;
                q2.delete(0);
            end
            check("gap0_out", {a0, first0, busy0, done0}, e0);
            check("gap2_out", {a2, first2, busy2, done2}, e2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic [3:0] r, input int cut);
        int td;
        start   = 1'b1;
        pattern = p;
        reps    = r;
        model(0, p, int'(r), cyc, cut, td);
        model(2, p, int'(r), cyc, cut, td);
        tick;
        start   = 1'b0;
        pattern = ~p;
        reps    = ~r;
    endtask

    task automatic wait_quiet;
        while (cyc <= tlast + 1) tick;
    endtask

    initial begin
        int s;
        int ts;
        int td;
        n_checks = 0;
        n_fail   = 0;
        tlast    = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        reps     = '0;
        tick;
        chk_en = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;

        // Single repetition, then three repetitions, then reps=0.
        send(8'hF0, 4'd1, BIG);
        wait_quiet;
        send(8'hA5, 4'd3, BIG);
        wait_quiet;
        send(8'h5A, 4'd0, BIG);
        wait_quiet;

        // start with new inputs during an active transmission is ignored.
        send(8'hF0, 4'd1, BIG);
        tick; tick; tick;
        start   = 1'b1;
        pattern = 8'h0F;
        reps    = 4'd5;
        tick;
        start = 1'b0;
        wait_quiet;

        // Reset in cycle 5 of a transmission aborts it without done.
        s = cyc;
        send(8'hF0, 4'd1, s + 5);
        while (cyc < s + 5) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        wait_quiet;
        send(8'h96, 4'd2, BIG);
        wait_quiet;

        // Reset wins over start in the same cycle.
        start = 1'b1;
        reset = 1'b1;
        reps  = 4'd1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        tick; tick; tick;

        // start held high: back-to-back transmissions separated by DONE + IDLE.
        s       = cyc;
        start   = 1'b1;
        pattern = 8'hC3;
        reps    = 4'd2;
        ts = s;
        while (ts <= s + 39) begin
            model(0, 8'hC3, 2, ts, BIG, td);
            ts = td + 1;
        end
        ts = s;
        while (ts <= s + 39) begin
            model(2, 8'hC3, 2, ts, BIG, td);
            ts = td + 1;
        end
        repeat (40) tick;
        start = 1'b0;
        wait_quiet;

        // Maximum repetition count.
        send(8'h81, 4'd15, BIG);
        wait_quiet;

        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), 4'($urandom_range(0, 4)), BIG);
            wait_quiet;
        end

        tick; tick;
        check("gap0_drain", 4'(q0.size()), 4'd0);
        check("gap2_drain", 4'(q2.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d got no finish expected finish", cyc);
        $fatal(1, "time limit");
    end

endmodule
